// File: rtl/key_pkg.sv
// Shared FSM state encoding and default 50 MHz timing for the key event path.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_DEB   = 3'd1,
        HELD        = 3'd2,
        LONG_HELD   = 3'd3,
        RELEASE_DEB = 3'd4
    } key_state_e;

    localparam int unsigned DEF_SAMPLE_DIV     = 5000;  // 100 us at 50 MHz
    localparam int unsigned DEF_STABLE_SAMPLES = 4;
    localparam int unsigned DEF_LONG_TICKS     = 10000; // 1 s
    localparam int unsigned DEF_REPEAT_TICKS   = 2000;  // 200 ms
    localparam int unsigned DEF_ACTIVE_LOW     = 1;

endpackage

// File: rtl/key_sample_tick.sv
// Free-running divider producing a one-cycle sample tick every SAMPLE_DIV clocks.
module key_sample_tick
    import key_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);

    localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DW-1:0] div_q;

    assign tick = (div_q == DW'(SAMPLE_DIV - 1));

    // Count 0..SAMPLE_DIV-1 and wrap on the tick cycle.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Debounces a raw key pin and decodes press/release/click/long/repeat one-cycle events.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS,
    parameter int unsigned ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_level,
    output logic key_pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DEB_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);
    localparam logic        INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic              tick;
    logic [1:0]        sync_q;
    logic              act;
    key_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d, deb_inc;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              long_flag_q, long_flag_d;
    logic              kp_q, kp_d;
    logic              press_q, press_d, release_q, release_d, click_q, click_d;
    logic              long_q, long_d, repeat_q, repeat_d;
    logic              accept_press, accept_release, start_release;

    key_sample_tick #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .tick   (tick)
    );

    // Two-flop synchronizer, reset to the released pin level.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync_q <= {2{INACTIVE}};
        end else begin
            sync_q <= {sync_q[0], key_level};
        end
    end

    assign act      = sync_q[1] ^ INACTIVE;
    assign deb_inc  = deb_q + DEB_W'(1);
    assign hold_inc = hold_q + HOLD_W'(1);

    // Next-state, counters and pulse decisions; only tick cycles move the FSM.
    always_comb begin
        state_d        = state_q;
        deb_d          = deb_q;
        hold_d         = hold_q;
        rep_d          = rep_q;
        long_flag_d    = long_flag_q;
        kp_d           = kp_q;
        press_d        = 1'b0;
        release_d      = 1'b0;
        click_d        = 1'b0;
        long_d         = 1'b0;
        repeat_d       = 1'b0;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        start_release  = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (act) begin
                        if (STABLE_SAMPLES == 1) begin
                            accept_press = 1'b1;
                        end else begin
                            state_d = PRESS_DEB;
                            deb_d   = DEB_W'(1);
                        end
                    end
                end
                PRESS_DEB: begin
                    if (!act) begin
                        state_d = IDLE;
                    end else if (deb_inc == DEB_W'(STABLE_SAMPLES)) begin
                        accept_press = 1'b1;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                HELD: begin
                    if (!act) begin
                        start_release = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                        if (hold_inc == HOLD_W'(LONG_TICKS - 1)) begin
                            state_d     = LONG_HELD;
                            long_d      = 1'b1;
                            long_flag_d = 1'b1;
                            rep_d       = '0;
                        end
                    end
                end
                LONG_HELD: begin
                    if (!act) begin
                        start_release = 1'b1;
                    end else if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
                RELEASE_DEB: begin
                    // Counters stay frozen so a bounce resumes the hold where it left off.
                    if (act) begin
                        state_d = long_flag_q ? LONG_HELD : HELD;
                    end else if (deb_inc == DEB_W'(STABLE_SAMPLES)) begin
                        accept_release = 1'b1;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start_release) begin
                if (STABLE_SAMPLES == 1) begin
                    accept_release = 1'b1;
                end else begin
                    state_d = RELEASE_DEB;
                    deb_d   = DEB_W'(1);
                end
            end
            if (accept_press) begin
                state_d     = HELD;
                press_d     = 1'b1;
                kp_d        = 1'b1;
                hold_d      = '0;
                long_flag_d = 1'b0;
            end
            if (accept_release) begin
                state_d   = IDLE;
                release_d = 1'b1;
                click_d   = !long_flag_q;
                kp_d      = 1'b0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            long_flag_q <= 1'b0;
            kp_q        <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            click_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            long_flag_q <= long_flag_d;
            kp_q        <= kp_d;
            press_q     <= press_d;
            release_q   <= release_d;
            click_q     <= click_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign key_pressed   = kp_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_key_event_decoder;

    localparam int unsigned SD = 4;
    localparam int unsigned SS = 3;
    localparam int unsigned LT = 8;
    localparam int unsigned RT = 3;

    // Event vector: {key_pressed, press, release, click, long, repeat}
    localparam logic [5:0] EV_PRESS   = 6'b110000;
    localparam logic [5:0] EV_CLICK   = 6'b001100;
    localparam logic [5:0] EV_RELEASE = 6'b001000;
    localparam logic [5:0] EV_LONG    = 6'b100010;
    localparam logic [5:0] EV_REPEAT  = 6'b100001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key = 1'b1;
    logic key_pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;

    typedef struct {
        logic [5:0] vec;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc;
    logic kp_prev = 1'b0;

    always #5 clk = ~clk;

    key_event_decoder #(
        .SAMPLE_DIV    (SD),
        .STABLE_SAMPLES(SS),
        .LONG_TICKS    (LT),
        .REPEAT_TICKS  (RT),
        .ACTIVE_LOW    (1)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst_n),
        .key_level    (key),
        .key_pressed  (key_pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    // Clock cycles since reset release; sample tick k lands on cycle 4*k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [5:0] outs();
        return {key_pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
    endfunction

    task automatic expect_evt(input logic [5:0] v, input int tick_no);
        exp_t e;
        e.vec = v;
        e.cyc = int'(SD) * tick_no;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        logic [5:0] v;
        v = outs();
        n_tests++;
        if (v !== 6'b0) begin
            n_fail++;
            $display("FAIL %s: outputs %b, required 000000", name, v);
        end
    endtask

    // Return 1 time unit after the clock edge that carries sample tick t.
    task automatic goto_tick(input int t);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (cyc != int'(SD) * t && guard < 2000);
        if (cyc != int'(SD) * t) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto_tick: cycle %0d, required %0d", cyc, int'(SD) * t);
        end
    endtask

    // Monitor: any pulse or key_pressed change is an event to match against the queue.
    always @(negedge clk) begin
        logic [5:0] v;
        exp_t e;
        if (!rst_n) begin
            kp_prev = 1'b0;
        end else begin
            v = outs();
            if (v[4:0] != 5'b0 || v[5] != kp_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %b at cycle %0d, required none", v, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (v !== e.vec) begin
                        n_fail++;
                        $display("FAIL event_value: got %b, required %b", v, e.vec);
                    end
                    n_tests++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL event_time: cycle %0d, required %0d", cyc, e.cyc);
                    end
                end
            end
            kp_prev = v[5];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset holds everything low, then 20 idle ticks produce nothing
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        goto_tick(20);
        check_zero("idle_20_ticks");

        // 2: two-tick glitch is rejected
        key = 1'b0;
        goto_tick(22);
        key = 1'b1;
        goto_tick(26);
        check_zero("glitch_rejected");

        // 3: short press -> press, then release with click
        key = 1'b0;
        expect_evt(EV_PRESS, 29);
        expect_evt(EV_CLICK, 34);
        goto_tick(31);
        key = 1'b1;
        goto_tick(36);

        // 4: long hold -> press, long, repeats every 3 ticks, release without click
        key = 1'b0;
        expect_evt(EV_PRESS, 39);
        expect_evt(EV_LONG, 46);
        expect_evt(EV_REPEAT, 49);
        expect_evt(EV_REPEAT, 52);
        expect_evt(EV_REPEAT, 55);
        expect_evt(EV_RELEASE, 59);
        goto_tick(56);
        key = 1'b1;
        goto_tick(60);

        // 5: one-tick bounce while held; hold count resumes, long arrives 2 ticks later
        key = 1'b0;
        expect_evt(EV_PRESS, 63);
        expect_evt(EV_LONG, 72);
        expect_evt(EV_RELEASE, 75);
        goto_tick(65);
        key = 1'b1;
        goto_tick(66);
        key = 1'b0;
        goto_tick(72);
        key = 1'b1;
        goto_tick(78);

        // 6: reset during long hold, key still down -> fresh press after reset
        key = 1'b0;
        expect_evt(EV_PRESS, 81);
        expect_evt(EV_LONG, 88);
        goto_tick(89);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_long");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_evt(EV_PRESS, 3);
        expect_evt(EV_CLICK, 7);
        goto_tick(4);
        key = 1'b1;
        goto_tick(10);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d left in queue, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
